// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
package mult_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE,
        S_FIX  = ST_FIX
    } state_t;

endpackage

// File: rtl/mult_add_select.sv
// Upper-half update for one shift-add step: adds the multiplicand to the accumulator's
// upper half and selects sum or pass-through on the accumulator LSB.
module mult_add_select #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc_hi_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic             sel_i,
    output logic [WIDTH:0]   result_o
);

    logic [WIDTH:0] sum;

    // Carry bit of acc_hi_i is always zero entering a step, so only the low WIDTH bits are added.
    assign sum = {1'b0, acc_hi_i[WIDTH-1:0]} + {1'b0, mcand_i};

    for (genvar i = 0; i <= WIDTH; i++) begin : g_mux
        mult_mux2 u_mux (
            .a_i   (acc_hi_i[i]),
            .b_i   (sum[i]),
            .sel_i (sel_i),
            .y_o   (result_o[i])
        );
    end

endmodule

// File: rtl/mult_mux2.sv
// Bit-level 2:1 multiplexer: y_o = sel_i ? b_i : a_i.
module mult_mux2 (
    input  logic a_i,
    input  logic b_i,
    input  logic sel_i,
    output logic y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 sequential shift-add multiplier producing a 2*WIDTH-bit product with a done pulse.
// Optional signed mode is enabled by defining SEQ_MULT_SIGNED_EN.
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               signed_op,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH:0]       upper_next;
    logic [WIDTH-1:0]     op_a, op_b;

`ifdef SEQ_MULT_SIGNED_EN
    logic fix_q, fix_d;
    logic neg_q, neg_d;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        // -2**(WIDTH-1) maps onto itself, which is the correct unsigned magnitude.
        return v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign op_a = signed_op ? magnitude(a) : a;
    assign op_b = signed_op ? magnitude(b) : b;
`else
    assign op_a = a;
    assign op_b = b;
`endif

    mult_add_select #(
        .WIDTH (WIDTH)
    ) u_add_select (
        .acc_hi_i (acc_q[2*WIDTH:WIDTH]),
        .mcand_i  (mcand_q),
        .sel_i    (acc_q[0]),
        .result_o (upper_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            fix_q     <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SEQ_MULT_SIGNED_EN
            fix_q     <= fix_d;
            neg_q     <= neg_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
        fix_d     = fix_q;
        neg_d     = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = op_a;
                    acc_d   = {1'b0, {WIDTH{1'b0}}, op_b};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
`ifdef SEQ_MULT_SIGNED_EN
                    fix_d   = signed_op;
                    neg_d   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
                end
            end
            S_RUN: begin
                // Conditional add and right shift happen in the same cycle; carry enters the MSB.
                acc_d = {upper_next, acc_q[WIDTH-1:0]} >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SEQ_MULT_SIGNED_EN
                    state_d = fix_q ? S_FIX : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef SEQ_MULT_SIGNED_EN
            S_FIX: begin
                if (neg_q) begin
                    acc_d = {1'b0, negate(acc_q[2*WIDTH-1:0])};
                end
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                // The registered done/product become visible one edge after this state.
                done_d    = 1'b1;
                busy_d    = 1'b0;
                product_d = acc_q[2*WIDTH-1:0];
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed self-checking bench for seq_shift_add_multiplier (signed cases need SEQ_MULT_SIGNED_EN).
module tb_seq_shift_add_multiplier;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] product;
    logic        busy;
    logic        done;
`ifdef SEQ_MULT_SIGNED_EN
    logic        signed_op;
`endif

    int tests;
    int fails;

    seq_shift_add_multiplier #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_op (signed_op),
`endif
        .a         (a),
        .b         (b),
        .product   (product),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands with start for exactly one rising edge; returns 1ns after the accepting edge.
    task automatic do_start(input logic [31:0] ta, input logic [31:0] tb);
        @(negedge clk);
        a     = ta;
        b     = tb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen, bounded by limit.
    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (done !== 1'b1 && n < limit);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (product !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: product=%h busy=%b done=%b, want 0/0/0", product, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int n;
        do_start(32'd3, 32'd5);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_busy: busy=%b, want 1", busy);
        end
        wait_done(100, n);
        tests++;
        if (n !== 33) begin
            fails++;
            $display("FAIL basic_latency: %0d edges, want 33", n);
        end
        tests++;
        if (product !== 64'd15 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_product: product=%h busy=%b, want 15/0", product, busy);
        end
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL basic_done_pulse: done=%b one cycle later, want 0", done);
        end
    endtask

    task automatic test_max();
        int n;
        do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(100, n);
        tests++;
        if (n !== 33 || product !== 64'hFFFF_FFFE_0000_0001) begin
            fails++;
            $display("FAIL max_operands: n=%0d product=%h, want 33/fffffffe00000001", n, product);
        end
    endtask

    task automatic test_zero_hold();
        int n;
        int bad;
        do_start(32'd0, 32'h1234_5678);
        wait_done(100, n);
        tests++;
        if (n !== 33 || product !== 64'd0) begin
            fails++;
            $display("FAIL zero_operand: n=%0d product=%h, want 33/0", n, product);
        end
        do_start(32'h8000_0000, 32'd2);
        wait_done(100, n);
        tests++;
        if (n !== 33 || product !== 64'h1_0000_0000) begin
            fails++;
            $display("FAIL msb_times_two: n=%0d product=%h, want 33/100000000", n, product);
        end
        bad = 0;
        a = 32'hDEAD_BEEF;
        b = 32'h0BAD_F00D;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (product !== 64'h1_0000_0000 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL idle_hold: %0d bad idle cycles, product=%h, want 100000000 held", bad, product);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        do_start(32'd7, 32'd6);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            if (n == 9) begin
                a     = 32'd9;
                b     = 32'd9;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        tests++;
        if (n !== 33 || product !== 64'd42) begin
            fails++;
            $display("FAIL start_while_busy: n=%0d product=%0d, want 33/42", n, product);
        end
        a     = 32'd2;
        b     = 32'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tests++;
        if (done !== 1'b0 || busy !== 1'b1 || product !== 64'd42) begin
            fails++;
            $display("FAIL b2b_accept: done=%b busy=%b product=%0d, want 0/1/42", done, busy, product);
        end
        wait_done(100, n);
        tests++;
        if (n !== 33 || product !== 64'd4) begin
            fails++;
            $display("FAIL b2b_second: n=%0d product=%0d, want 33/4", n, product);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int pulses;
        do_start(32'd100, 32'd100);
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if (product !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_run: product=%h busy=%b done=%b, want 0/0/0", product, busy, done);
        end
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL reset_no_done: %0d cycles with done/busy after abort, want 0", pulses);
        end
        do_start(32'd11, 32'd13);
        wait_done(100, n);
        tests++;
        if (n !== 33 || product !== 64'd143) begin
            fails++;
            $display("FAIL after_reset: n=%0d product=%0d, want 33/143", n, product);
        end
    endtask

`ifdef SEQ_MULT_SIGNED_EN
    task automatic test_signed();
        int n;
        signed_op = 1'b1;
        do_start(32'hFFFF_FFFD, 32'd7);
        wait_done(100, n);
        tests++;
        if (n !== 34 || product !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            fails++;
            $display("FAIL signed_neg3x7: n=%0d product=%h, want 34/ffffffffffffffeb", n, product);
        end
        do_start(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(100, n);
        tests++;
        if (n !== 34 || product !== 64'h0000_0000_8000_0000) begin
            fails++;
            $display("FAIL signed_minint: n=%0d product=%h, want 34/0000000080000000", n, product);
        end
        signed_op = 1'b0;
        do_start(32'hFFFF_FFFD, 32'd7);
        wait_done(100, n);
        tests++;
        if (n !== 33 || product !== 64'h0000_0006_FFFF_FFEB) begin
            fails++;
            $display("FAIL unsigned_in_signed_build: n=%0d product=%h, want 33/00000006ffffffeb", n, product);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        reset = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
        signed_op = 1'b0;
`endif
        test_reset();
        test_basic();
        test_max();
        test_zero_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef SEQ_MULT_SIGNED_EN
        test_signed();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
